ram_port_arbiter: RTL

Two-client arbiter and sequencer for the 4096 x 64 dual-port RAM (`ram_4096`). It accepts read and write requests from two independent clients, A and B, over req/gnt handshakes. It drives the RAM's separate write and read ports from registered control, and routes returned read data to the requesting client. It sits directly in front of `ram_4096`; the RAM ports connect one-to-one.

---
 rtl/ram_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 34 +++
 rtl/ram_port_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared types and sizing for the ram_4096 front-end arbiter.
// Client identities and the read-return tag are defined once here.
package ram_pkg;

  localparam int RAM_WIDTH = 64;
  localparam int ADDR_SIZE = 12;

  typedef enum logic {
    CLIENT_A = 1'b0,
    CLIENT_B = 1'b1
  } client_id_t;

  typedef struct packed {
    logic       valid;
    client_id_t client;
  } rd_tag_t;

  // Maps a one-hot two-way grant onto the client it selects.
  function automatic client_id_t grant_to_client(input logic [1:0] gnt);
    return gnt[1] ? CLIENT_B : CLIENT_A;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie, the client not last accepted wins.
// The pointer moves only when the granted request is actually accepted.
module rr_arb2
  import ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  client_id_t prio;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || prio == CLIENT_A)) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= CLIENT_A;
    end else if (accept) begin
      prio <= gnt[0] ? CLIENT_B : CLIENT_A;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-client read/write sequencer in front of ram_4096: parallel read and write
// arbitration, registered RAM port control, and tagged read-data return.
module ram_port_arbiter #(
  parameter int RAM_WIDTH = ram_pkg::RAM_WIDTH,
  parameter int ADDR_SIZE = ram_pkg::ADDR_SIZE,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_SIZE-1:0] a_addr,
  input  logic [RAM_WIDTH-1:0] a_wdata,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [RAM_WIDTH-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_SIZE-1:0] b_addr,
  input  logic [RAM_WIDTH-1:0] b_wdata,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [RAM_WIDTH-1:0] b_rdata,
  output logic                 ram_write,
  output logic [ADDR_SIZE-1:0] ram_wr_address,
  output logic [RAM_WIDTH-1:0] ram_data_in,
  output logic                 ram_read,
  output logic [ADDR_SIZE-1:0] ram_rd_address,
  input  logic [RAM_WIDTH-1:0] ram_data_out
);

  import ram_pkg::*;

  logic [1:0]           wr_req;
  logic [1:0]           rd_req;
  logic [1:0]           wr_win;
  logic [1:0]           rd_win;
  logic                 wr_fire;
  logic                 rd_fire;
  logic                 collide;
  logic [ADDR_SIZE-1:0] wr_addr_sel;
  logic [ADDR_SIZE-1:0] rd_addr_sel;
  logic [RAM_WIDTH-1:0] wr_data_sel;
  rd_tag_t              new_tag;
  rd_tag_t              ret_tag;
  rd_tag_t              tag_pipe [RD_LAT+1];

  // Requests are masked during reset so no grant can be seen or accepted.
  assign wr_req = {b_req &  b_we, a_req &  a_we} & {2{~rst}};
  assign rd_req = {b_req & ~b_we, a_req & ~a_we} & {2{~rst}};

  rr_arb2 u_wr_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (wr_req),
    .accept (wr_fire),
    .gnt    (wr_win)
  );

  rr_arb2 u_rd_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (rd_req),
    .accept (rd_fire),
    .gnt    (rd_win)
  );

  // A read hitting the address being written this cycle is held off one
  // cycle so it issues after the write lands and returns the new data.
  always_comb begin
    wr_addr_sel    = wr_win[1] ? b_addr  : a_addr;
    wr_data_sel    = wr_win[1] ? b_wdata : a_wdata;
    rd_addr_sel    = rd_win[1] ? b_addr  : a_addr;
    collide        = (|wr_win) && (|rd_win) && (rd_addr_sel == wr_addr_sel);
    wr_fire        = |wr_win;
    rd_fire        = (|rd_win) && !collide;
    a_gnt          = wr_win[0] | (rd_win[0] & ~collide);
    b_gnt          = wr_win[1] | (rd_win[1] & ~collide);
    new_tag.valid  = rd_fire;
    new_tag.client = grant_to_client(rd_win);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_write      <= 1'b0;
      ram_read       <= 1'b0;
      ram_wr_address <= '0;
      ram_data_in    <= '0;
      ram_rd_address <= '0;
    end else begin
      ram_write <= wr_fire;
      ram_read  <= rd_fire;
      if (wr_fire) begin
        ram_wr_address <= wr_addr_sel;
        ram_data_in    <= wr_data_sel;
      end
      if (rd_fire) begin
        ram_rd_address <= rd_addr_sel;
      end
    end
  end

  // Stage 0 lines up with ram_read; stage RD_LAT lines up with valid ram_data_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= new_tag;
      for (int i = 1; i <= RD_LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign ret_tag = tag_pipe[RD_LAT];

  // NOTE: only these small return registers are reset; the RAM array behind the ports is never cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= ret_tag.valid && (ret_tag.client == CLIENT_A);
      b_rvalid <= ret_tag.valid && (ret_tag.client == CLIENT_B);
      if (ret_tag.valid && ret_tag.client == CLIENT_A) begin
        a_rdata <= ram_data_out;
      end
      if (ret_tag.valid && ret_tag.client == CLIENT_B) begin
        b_rdata <= ram_data_out;
      end
    end
  end

endmodule
